// File: rtl/latch_write_scheduler_pkg.sv
// Shared definitions for latch_write_scheduler: FSM encodings and sizing helpers.
package latch_write_scheduler_pkg;

  localparam logic [2:0] LWS_IDLE  = 3'd0;
  localparam logic [2:0] LWS_SETUP = 3'd1;
  localparam logic [2:0] LWS_OPEN  = 3'd2;
  localparam logic [2:0] LWS_HOLD  = 3'd3;
  localparam logic [2:0] LWS_ACK   = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = LWS_IDLE,
    StSetup = LWS_SETUP,
    StOpen  = LWS_OPEN,
    StHold  = LWS_HOLD,
    StAck   = LWS_ACK
  } lws_state_e;

  // Bits needed to encode values 0..value-1 (minimum 1).
  function automatic int unsigned lws_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned lws_max3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_write_scheduler_if.sv
// Requester-side bus of latch_write_scheduler: request/data in, grant/latch/ack out.
interface latch_write_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      latch_d;
  logic                  latch_en;
  logic                  ack;
  logic                  busy;

  modport master (
    output req, req_data,
    input  grant, latch_d, latch_en, ack, busy
  );

  modport slave (
    input  req, req_data,
    output grant, latch_d, latch_en, ack, busy
  );
endinterface

// File: rtl/latch_write_scheduler_rr_arbiter.sv
// Combinational one-hot arbiter. Round-robin from i_ptr by default; with
// LWS_FIXED_PRIO_EN defined it becomes a lowest-index-wins priority encoder.
module latch_write_scheduler_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant
);

`ifdef LWS_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Lowest requesting index wins.
  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_req[i] && (o_grant == '0)) o_grant[i] = 1'b1;
    end
  end
`else
  // Search upward from the pointer with wrap; the pointer slot has top priority.
  always_comb begin
    logic w_found;
    o_grant = '0;
    w_found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] && (i == (32'(i_ptr) + off) % NREQ)) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/latch_write_scheduler.sv
// Shares one level-sensitive latch among NREQ requesters. Sequences the latch
// enable as setup -> open -> hold -> ack with LatchD frozen from grant to ack.
// Optional macro LWS_FIXED_PRIO_EN selects fixed lowest-index priority.
module latch_write_scheduler
  import latch_write_scheduler_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic                    i_clk,
  input logic                    i_rst,
  latch_write_scheduler_if.slave lws_if
);

  localparam int unsigned CNT_W = lws_clog2(lws_max3(SETUP_CYC, OPEN_CYC, HOLD_CYC) + 1);
  localparam int unsigned PTR_W = lws_clog2(NREQ);

  lws_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [NREQ-1:0]  r_grant, w_grant_d, w_arb_grant;
  logic [WIDTH-1:0] r_latch_d, w_latch_d_d;
  logic             r_latch_en, r_ack, r_busy;
  logic [PTR_W-1:0] w_ptr;

  latch_write_scheduler_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (lws_if.req),
    .i_ptr   (w_ptr),
    .o_grant (w_arb_grant)
  );

`ifdef LWS_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0] r_ptr, w_ptr_d;
  assign w_ptr = r_ptr;

  // Advance the pointer past the winner as the transaction retires.
  always_comb begin
    w_ptr_d = r_ptr;
    if (r_state == StAck) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (r_grant[i]) w_ptr_d = PTR_W'((i + 1) % NREQ);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ptr <= '0;
    else       r_ptr <= w_ptr_d;
  end
`endif

  // Next-state, phase counter and grant/data capture.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + CNT_W'(1);
    w_grant_d   = r_grant;
    w_latch_d_d = r_latch_d;
    unique case (r_state)
      StIdle: begin
        if (|lws_if.req) begin
          w_state_d = StSetup;
          w_grant_d = w_arb_grant;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) w_latch_d_d = lws_if.req_data[i*WIDTH +: WIDTH];
          end
        end
      end
      StSetup: if (r_cnt == CNT_W'(SETUP_CYC - 1)) w_state_d = StOpen;
      StOpen:  if (r_cnt == CNT_W'(OPEN_CYC - 1))  w_state_d = StHold;
      StHold:  if (r_cnt == CNT_W'(HOLD_CYC - 1))  w_state_d = StAck;
      StAck: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
    endcase
    // Counter restarts on every phase change, so it never needs to wrap.
    if ((w_state_d != r_state) || (r_state == StIdle)) w_cnt_d = '0;
  end

  // State plus registered outputs decoded from the next state (no glitches).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_latch_d  <= '0;
      r_latch_en <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_grant    <= w_grant_d;
      r_latch_d  <= w_latch_d_d;
      r_latch_en <= (w_state_d == StOpen);
      r_ack      <= (w_state_d == StAck);
      r_busy     <= (w_state_d != StIdle);
    end
  end

  assign lws_if.grant    = r_grant;
  assign lws_if.latch_d  = r_latch_d;
  assign lws_if.latch_en = r_latch_en;
  assign lws_if.ack      = r_ack;
  assign lws_if.busy     = r_busy;

endmodule

// File: doc/latch_write_scheduler.md
Name: latch_write_scheduler

Overview:
- Shares one level-sensitive latch register between NREQ requesters.
- Arbitrates among them round-robin, captures the winner's data, and sequences the latch enable as setup → transparent → hold → acknowledge.
- Sits between the requester logic and a latch-based register. LatchEnable drives the latch's Clock input; LatchD drives the latch's D input.
- Guarantees D is stable around every transparent window.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: data width.
- SETUP_CYC, 1: cycles LatchD is stable before LatchEnable rises (≥1).
- OPEN_CYC, 2: cycles LatchEnable stays high (≥1).
- HOLD_CYC, 1: cycles LatchD stays stable after LatchEnable falls (≥1).

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  NREQ  per-requester request level; held until Ack.
- ReqData  in  NREQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH].
- Grant  out  NREQ  one-hot owner of the current transaction.
- LatchD  out  WIDTH  registered data to the latch D input.
- LatchEnable  out  1  registered latch enable, glitch-free.
- Ack  out  1  one-cycle completion pulse to the granted requester.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - Grant=0, LatchD=0, LatchEnable=0, Ack=0, Busy=0.
  - State=IDLE, round-robin pointer=0, all counters=0.
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK.
  - IDLE: at an edge with |Req, the arbiter picks a winner. Grant←one-hot(winner), LatchD←ReqData[winner], go to SETUP. If Req=0, stay in IDLE.
  - SETUP: lasts SETUP_CYC cycles, then goes to OPEN.
  - OPEN: LatchEnable=1 for exactly OPEN_CYC cycles, then goes to HOLD.
  - HOLD: LatchEnable=0 for HOLD_CYC cycles, then goes to ACK.
  - ACK: Ack=1 for one cycle with Grant still held. Next edge: Grant←0, pointer←winner+1 (mod NREQ), go to IDLE.
- Timing with the defaults (edge e0 = grant): LatchEnable high e1..e3, Ack high e4..e5, IDLE at e5. The next grant is possible at e6, so there is at least one IDLE cycle between transactions.
- Arbitration: the search starts at the pointer and wraps upward. The pointer itself has highest priority.
- Data stability: LatchD is loaded only at grant and is constant through SETUP, OPEN, HOLD and ACK. ReqData changes after grant are ignored.
- Req dropped mid-transaction: the sequence completes unchanged and Ack still pulses. The requester ignores it.
- Req rising during a transaction: no effect until IDLE.
- LatchEnable and Ack are decoded from registered state only; there is no combinational path from Req.
- One phase counter of width clog2(max(SETUP_CYC,OPEN_CYC,HOLD_CYC)+1) is cleared on every state change. It never wraps; the terminal count forces the transition.
- Reset mid-transaction: outputs drop immediately, the latch keeps its last value, and no Ack is issued.

Optional Feature:
- Macro: LWS_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer register is removed and the pointer stays 0.
- Undefined: round-robin as above.
- Every other behaviour is identical in both builds.

Decomposition:
- Shared package (header): FSM state encodings (3-bit localparams LWS_IDLE..LWS_ACK) and a clog2 constant function.
- One sub-module, rr_arbiter:
  - Inputs: Req and pointer. Output: one-hot winner.
  - Combinational.
  - Replaced by a priority encoder under LWS_FIXED_PRIO_EN.

Test Plan (NREQ=4, WIDTH=8, SETUP_CYC=1, OPEN_CYC=2, HOLD_CYC=1):
- Single requester: Req=0001, data0=8'hA5 → Grant=0001 and LatchD=A5 at e0; LatchEnable high exactly 2 cycles (e1–e3); Ack single pulse at e4; Busy=0 from e5.
- All four requesters hold Req=1111 → grant order 0,1,2,3,0. LatchEnable pulses are never adjacent and always preceded by 1 stable LatchD cycle.
- Requester 2 changes data from 8'h3C to 8'hFF one cycle after grant → LatchD stays 3C until the next grant.
- Requester 1 drops Req during OPEN → LatchEnable still high 2 cycles, and Ack still pulses at e4.
- Reset asserted mid-OPEN between edges → LatchEnable, Grant, Busy and Ack go to 0 without a clock edge. After release with Req=1111, the first Grant=0001.
- Built with LWS_FIXED_PRIO_EN, Req=1010 held → every grant is 0010; requester 3 is never granted.
